pll_lock_supervisor: RTL

- Sits on the other side of the system PLL.
- Runs on the free-running 50 MHz reference clock.
- Drives the PLL's reset input and consumes its asynchronous lock indication.
- Sequences PLL reset, lock acquisition and lock-stability qualification, then releases a system reset for logic in the PLL output domain. Re-acquires automatically on lock loss and flags a hard fault after repeated lock timeouts.

---
 rtl/pll_sup_pkg.sv | 22 ++
 rtl/pll_lock_supervisor_sync_bit.sv | 28 ++
 rtl/pll_lock_supervisor.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    // One timer serves every state, so it is sized for the longest count.
    function automatic int timer_width(input int rst_cycles, input int timeout, input int stable);
        int m;
        m = rst_cycles;
        if (timeout > m) m = timeout;
        if (stable > m) m = stable;
        if ($clog2(m) < 1) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, cleared by reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock acquisition and stability qualification, then
// releases the system reset; retries on timeout and latches a fault.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 1000000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3,
    parameter int CNT_W              = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             clear_fault,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] lock_lost_cnt
);

    localparam int TW = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE_CYCLES);
    localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

    localparam logic [TW-1:0] RST_LAST     = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);

    logic             locked_s;
    pll_state_e       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0] lock_lost_cnt_q, lock_lost_cnt_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(refclk),
        .rst(rst),
        .d  (pll_locked),
        .q  (locked_s)
    );

    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        retry_d         = retry_q;
        lock_lost_cnt_d = lock_lost_cnt_q;

        case (state_q)
            PLL_RST: begin
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_d = STABLE;
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    timer_d = '0;
                    if (retry_q == RETRY_LAST) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = PLL_RST;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RUN;
                    timer_d = '0;
                    retry_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = PLL_RST;
                    timer_d = '0;
                    if (lock_lost_cnt_q != '1) begin
                        lock_lost_cnt_d = lock_lost_cnt_q + 1'b1;
                    end
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_d = PLL_RST;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = PLL_RST;
                timer_d = '0;
            end
        endcase

        // Outputs follow the next state so they switch on the transition edge.
        pll_rst_d = (state_d == PLL_RST) || (state_d == FAULT);
        sys_rst_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q         <= PLL_RST;
            timer_q         <= '0;
            retry_q         <= '0;
            lock_lost_cnt_q <= '0;
            pll_rst_q       <= 1'b1;
            sys_rst_q       <= 1'b1;
            ready_q         <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            retry_q         <= retry_d;
            lock_lost_cnt_q <= lock_lost_cnt_d;
            pll_rst_q       <= pll_rst_d;
            sys_rst_q       <= sys_rst_d;
            ready_q         <= ready_d;
            fault_q         <= fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign lock_lost_cnt = lock_lost_cnt_q;

endmodule
